prog_timer_bank: RTL and testbench
==================================

Name: prog_timer_bank

Overview:
- Parametrised multi-channel timer. Supersedes the fixed-count one-shot, periodic, long-press and PWM-style counters with one configurable bank.
- Each channel runs as one-shot, periodic (with duty-cycle level output) or hold-to-trigger.
- All channels share a programmable prescaler.
- Sits between the 100 MHz system clock and game/UI logic: light blinking, countdowns, long-press detection.

Parameters:
- CH, 4, number of independent timer channels (1..16).
- W, 32, counter/period/duty width in bits.
- PRESCALE, 1, system clocks per count enable (1 = count every clock).
- CHW, $clog2(CH) (min 1), width of the channel-select field.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, reset: asynchronous, active-high.
- ld_en, in, 1, configuration write strobe, one cycle.
- ld_ch, in, CHW, channel written when ld_en=1.
- ld_mode, in, 2, mode: 00 one-shot, 01 periodic, 10 hold, 11 treated as one-shot.
- ld_period, in, W, terminal count P.
- ld_duty, in, W, periodic-mode high count D.
- start, in, CH, per-channel start pulse; in hold mode, a level.
- stop, in, CH, per-channel pause (level; counting freezes while high).
- clear, in, CH, per-channel synchronous abort to IDLE.
- tick, out, CH, one-clock pulse on each terminal count.
- level, out, CH, mode-dependent level (see below).
- busy, out, CH, channel in RUN or PAUSE.
- done, out, CH, sticky terminal flag (one-shot/hold).

Behaviour:
- Reset (async): all state cleared.
  - tick, level, busy, done = 0.
  - All counters, shadow and active period/duty/mode = 0.
  - Prescaler = 0. All channels IDLE.
- Prescaler: free-running 0..PRESCALE-1.
  - en=1 for one clock when it wraps.
  - PRESCALE=1 gives en=1 every clock.
  - Not re-synchronised by start, so the first interval may be up to PRESCALE-1 clocks short.
- Configuration:
  - ld_en writes the shadow mode/period/duty of ld_ch.
  - Shadow is copied to active on start (all modes) and on each periodic wrap.
  - A write never disturbs cnt or state.
  - ld_ch >= CH is ignored.
- Per-channel states: IDLE, RUN, PAUSE, DONE.
- Priority per channel per cycle: clear > start > stop > count.
- clear:
  - Next state IDLE, cnt=0, done=0.
  - No tick that cycle, even if a terminal count coincides.
- start (pulse; one-shot/periodic, any state):
  - Copy shadow to active, cnt=0, state RUN, done=0.
  - Restart mid-run is legal.
- Hold mode uses start as a level:
  - IDLE with start=1: RUN, cnt=0.
  - RUN with start=0: IDLE, cnt=0, no tick.
  - DONE with start=0: IDLE, done=0.
- stop:
  - RUN with stop=1: PAUSE, cnt frozen.
  - PAUSE with stop=0: RUN.
  - stop has no effect in IDLE or DONE.
- Count step, in RUN on a cycle with en=1:
  - If cnt==P: tick<=1 next cycle.
    - Periodic: cnt<=0, reload active from shadow.
    - One-shot/hold: state DONE, done<=1.
  - Else cnt<=cnt+1.
- Timing: with PRESCALE=1, tick is high in the clock P+1 cycles after the edge that sampled start. The periodic tick interval is (P+1)*PRESCALE clocks.
- P=0: periodic ticks on every en; one-shot ticks on the first en after start.
- cnt arithmetic is unsigned W-bit. cnt never exceeds P, so there is no wrap-around hazard.
- level:
  - Periodic: busy && (cnt < D). D=0 gives constant 0; D>P gives constant 1 while busy.
  - One-shot: equals busy.
  - Hold: equals done.
- level, busy and done derive combinationally from registered state only: no input-to-output combinational path.
- tick is registered.
- Channels are fully independent; simultaneous events on different channels never interact.

Test Plan:
- Reset mid-run: ch0 periodic P=9, start, assert rst at cycle 5 -> all outputs 0 immediately (async). After release, ch0 idle until a new start.
- One-shot: PRESCALE=1, ch1 mode 00 P=4, start pulse at edge 0 -> busy=1 for edges 1..5. tick high exactly one clock after edge 5. done=1 held; second tick never occurs.
- Periodic PWM: ch2 P=9 D=3 -> tick every 10 clocks, level high 3 of every 10. Load P=4 mid-run -> the new 5-clock period starts after the next wrap, not before.
- Hold: ch3 mode 10 P=7. start high 5 clocks, then low -> no tick, done=0. start high 12 clocks -> single tick 9 clocks after rise, done=1 until start falls.
- Priorities: ch0 periodic P=2. stop high for 6 clocks -> no tick and cnt frozen; counting resumes from the frozen value. clear and start together on the terminal cycle -> IDLE, no tick.
- PRESCALE=4, CH=2, P=1 periodic -> tick every 8 clocks. Concurrent one-shot on the other channel is unaffected.

Source files
------------

// File: rtl/prog_timer_bank.sv
// prog_timer_bank: bank of CH timers (one-shot / periodic PWM / hold-to-trigger)
// Ports: clk, rst, ld_* config write, start/stop/clear per channel; tick/level/busy/done out.
module prog_timer_bank #(
  parameter int CH       = 4,
  parameter int W        = 32,
  parameter int PRESCALE = 1,
  parameter int CHW      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld_en,
  input  logic [CHW-1:0] ld_ch,
  input  logic [1:0]     ld_mode,
  input  logic [W-1:0]   ld_period,
  input  logic [W-1:0]   ld_duty,
  input  logic [CH-1:0]  start,
  input  logic [CH-1:0]  stop,
  input  logic [CH-1:0]  clear,
  output logic [CH-1:0]  tick,
  output logic [CH-1:0]  level,
  output logic [CH-1:0]  busy,
  output logic [CH-1:0]  done
);

  localparam int PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);
  localparam logic [1:0] M_PER  = 2'b01;
  localparam logic [1:0] M_HOLD = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  // Shared free-running prescaler; start does not resync it.
  logic [PSW-1:0] pcnt;
  logic           en;

  assign en = (pcnt == PS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (en) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PSW'(1);
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    state_t       st;
    logic [W-1:0] cnt;
    logic [W-1:0] sh_p, sh_d, ac_p, ac_d;
    logic [1:0]   sh_m, ac_m;
    logic         tick_r;
    logic         wr, hold, go, drop;
    logic         is_busy, is_done;

    // ld_ch values >= CH match no channel and are dropped.
    assign wr = ld_en && (ld_ch == CHW'(c));

    // In IDLE the mode about to be loaded decides how start is read.
    assign hold = (st == IDLE) ? (sh_m == M_HOLD)
                               : (ac_m == M_HOLD);
    assign go   = hold ? ((st == IDLE) && start[c]) : start[c];
    assign drop = hold && !start[c] && (st != IDLE);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st     <= IDLE;
        cnt    <= '0;
        sh_p   <= '0;
        sh_d   <= '0;
        sh_m   <= '0;
        ac_p   <= '0;
        ac_d   <= '0;
        ac_m   <= '0;
        tick_r <= 1'b0;
      end else begin
        tick_r <= 1'b0;
        if (wr) begin
          sh_m <= ld_mode;
          sh_p <= ld_period;
          sh_d <= ld_duty;
        end
        if (clear[c]) begin
          st  <= IDLE;
          cnt <= '0;
        end else if (go) begin
          st   <= RUN;
          cnt  <= '0;
          ac_m <= sh_m;
          ac_p <= sh_p;
          ac_d <= sh_d;
        end else if (drop) begin
          st  <= IDLE;
          cnt <= '0;
        end else if (st == RUN && stop[c]) begin
          st <= PAUSE;
        end else if (st == PAUSE && !stop[c]) begin
          st <= RUN;
        end else if (st == RUN && en) begin
          if (cnt == ac_p) begin
            tick_r <= 1'b1;
            if (ac_m == M_PER) begin
              cnt  <= '0;
              ac_m <= sh_m;
              ac_p <= sh_p;
              ac_d <= sh_d;
            end else begin
              st <= DONE;
            end
          end else begin
            cnt <= cnt + W'(1);
          end
        end
      end
    end

    assign is_busy  = (st == RUN) || (st == PAUSE);
    assign is_done  = (st == DONE);
    assign busy[c]  = is_busy;
    assign done[c]  = is_done;
    assign tick[c]  = tick_r;
    assign level[c] = (ac_m == M_PER)  ? (is_busy && (cnt < ac_d)) :
                      (ac_m == M_HOLD) ? is_done : is_busy;
  end

endmodule

// File: tb/tb_prog_timer_bank.sv
// tb_prog_timer_bank: directed + random checks of prog_timer_bank
// against a behavioural model, three parameter sets.
module tb_prog_timer_bank;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        ld_en0;
  logic [1:0]  ld_ch0, ld_mode0;
  logic [15:0] ld_p0, ld_d0;
  logic [3:0]  start0, stop0, clear0;
  logic [3:0]  tick0, level0, busy0, done0;

  logic        ld_en1;
  logic [0:0]  ld_ch1;
  logic [1:0]  ld_mode1;
  logic [7:0]  ld_p1, ld_d1;
  logic [1:0]  start1, stop1, clear1;
  logic [1:0]  tick1, level1, busy1, done1;

  logic        ld_en2;
  logic [1:0]  ld_ch2, ld_mode2;
  logic [11:0] ld_p2, ld_d2;
  logic [2:0]  start2, stop2, clear2;
  logic [2:0]  tick2, level2, busy2, done2;

  prog_timer_bank #(.CH(4), .W(16), .PRESCALE(1)) u0 (
    .clk(clk), .rst(rst), .ld_en(ld_en0), .ld_ch(ld_ch0),
    .ld_mode(ld_mode0), .ld_period(ld_p0), .ld_duty(ld_d0),
    .start(start0), .stop(stop0), .clear(clear0),
    .tick(tick0), .level(level0), .busy(busy0), .done(done0));

  prog_timer_bank #(.CH(2), .W(8), .PRESCALE(4)) u1 (
    .clk(clk), .rst(rst), .ld_en(ld_en1), .ld_ch(ld_ch1),
    .ld_mode(ld_mode1), .ld_period(ld_p1), .ld_duty(ld_d1),
    .start(start1), .stop(stop1), .clear(clear1),
    .tick(tick1), .level(level1), .busy(busy1), .done(done1));

  prog_timer_bank #(.CH(3), .W(12), .PRESCALE(3)) u2 (
    .clk(clk), .rst(rst), .ld_en(ld_en2), .ld_ch(ld_ch2),
    .ld_mode(ld_mode2), .ld_period(ld_p2), .ld_duty(ld_d2),
    .start(start2), .stop(stop2), .clear(clear2),
    .tick(tick2), .level(level2), .busy(busy2), .done(done2));

  // Model: phase 0 idle, 1 run, 2 pause, 3 done.
  int m_st[3][4], m_cnt[3][4];
  int m_am[3][4], m_ap[3][4], m_ad[3][4];
  int m_sm[3][4], m_sp[3][4], m_sd[3][4];
  bit m_tick[3][4];
  int m_edges[3];

  int checks = 0;
  int errors = 0;
  int k = 0;

  function automatic int nch_of(int i);
    return (i == 0) ? 4 : (i == 1) ? 2 : 3;
  endfunction

  function automatic int ps_of(int i);
    return (i == 0) ? 1 : (i == 1) ? 4 : 3;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 3; i++) begin
      m_edges[i] = 0;
      for (int c = 0; c < 4; c++) begin
        m_st[i][c] = 0; m_cnt[i][c] = 0; m_tick[i][c] = 0;
        m_am[i][c] = 0; m_ap[i][c] = 0; m_ad[i][c] = 0;
        m_sm[i][c] = 0; m_sp[i][c] = 0; m_sd[i][c] = 0;
      end
    end
  endtask

  task automatic m_load(int i, int c);
    m_st[i][c] = 1;
    m_cnt[i][c] = 0;
    m_am[i][c] = m_sm[i][c];
    m_ap[i][c] = m_sp[i][c];
    m_ad[i][c] = m_sd[i][c];
  endtask

  task automatic m_step(int i, bit le, int lc, int lm, int lp, int ld,
                        bit [3:0] s, bit [3:0] sp, bit [3:0] cl);
    bit en, hold;
    int p;
    p = ps_of(i);
    // en fires on every PRESCALE-th edge since reset.
    en = ((m_edges[i] % p) == p - 1);
    m_edges[i]++;
    for (int c = 0; c < nch_of(i); c++) begin
      m_tick[i][c] = 0;
      hold = (m_st[i][c] == 0) ? (m_sm[i][c] == 2) : (m_am[i][c] == 2);
      if (cl[c]) begin
        m_st[i][c] = 0;
        m_cnt[i][c] = 0;
      end else if (hold && m_st[i][c] == 0) begin
        if (s[c]) m_load(i, c);
      end else if (hold && !s[c]) begin
        m_st[i][c] = 0;
        m_cnt[i][c] = 0;
      end else if (!hold && s[c]) begin
        m_load(i, c);
      end else if (m_st[i][c] == 1 && sp[c]) begin
        m_st[i][c] = 2;
      end else if (m_st[i][c] == 2 && !sp[c]) begin
        m_st[i][c] = 1;
      end else if (m_st[i][c] == 1 && en) begin
        if (m_cnt[i][c] == m_ap[i][c]) begin
          m_tick[i][c] = 1;
          if (m_am[i][c] == 1) m_load(i, c);
          else m_st[i][c] = 3;
        end else begin
          m_cnt[i][c] = m_cnt[i][c] + 1;
        end
      end
    end
    if (le && lc < nch_of(i)) begin
      m_sm[i][lc] = lm;
      m_sp[i][lc] = lp;
      m_sd[i][lc] = ld;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reset();
    end else begin
      m_step(0, ld_en0, int'(ld_ch0), int'(ld_mode0), int'(ld_p0),
             int'(ld_d0), start0, stop0, clear0);
      m_step(1, ld_en1, int'(ld_ch1), int'(ld_mode1), int'(ld_p1),
             int'(ld_d1), 4'(start1), 4'(stop1), 4'(clear1));
      m_step(2, ld_en2, int'(ld_ch2), int'(ld_mode2), int'(ld_p2),
             int'(ld_d2), 4'(start2), 4'(stop2), 4'(clear2));
    end
  end

  task automatic get_exp(int i, output logic [3:0] t, l, b, d);
    bit bz, dn;
    t = '0; l = '0; b = '0; d = '0;
    for (int c = 0; c < nch_of(i); c++) begin
      bz = (m_st[i][c] == 1) || (m_st[i][c] == 2);
      dn = (m_st[i][c] == 3);
      t[c] = m_tick[i][c];
      b[c] = bz;
      d[c] = dn;
      if (m_am[i][c] == 1) l[c] = bz && (m_cnt[i][c] < m_ad[i][c]);
      else if (m_am[i][c] == 2) l[c] = dn;
      else l[c] = bz;
    end
  endtask

  task automatic chkv(string nm, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @k=%0d t=%0t: got %b expected %b",
               nm, k, $time, act, exp);
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic compare();
    logic [3:0] t, l, b, d;
    get_exp(0, t, l, b, d);
    chkv("u0.tick", tick0, t);
    chkv("u0.level", level0, l);
    chkv("u0.busy", busy0, b);
    chkv("u0.done", done0, d);
    get_exp(1, t, l, b, d);
    chkv("u1.tick", 4'(tick1), t);
    chkv("u1.level", 4'(level1), l);
    chkv("u1.busy", 4'(busy1), b);
    chkv("u1.done", 4'(done1), d);
    get_exp(2, t, l, b, d);
    chkv("u2.tick", 4'(tick2), t);
    chkv("u2.level", 4'(level2), l);
    chkv("u2.busy", 4'(busy2), b);
    chkv("u2.done", 4'(done2), d);
  endtask

  task automatic cycle();
    @(negedge clk);
    k++;
    compare();
  endtask

  task automatic cfg0(int ch, int m, int p, int d);
    ld_en0 = 1'b1;
    ld_ch0 = 2'(ch);
    ld_mode0 = 2'(m);
    ld_p0 = 16'(p);
    ld_d0 = 16'(d);
    cycle();
    ld_en0 = 1'b0;
  endtask

  // Leaves k=0 at the negedge following the edge that sampled start.
  task automatic pulse0(int ch);
    start0[ch] = 1'b1;
    cycle();
    start0[ch] = 1'b0;
    k = 0;
  endtask

  function automatic logic [3:0] tog(logic [3:0] v, int n);
    logic [3:0] r;
    r = v;
    for (int c = 0; c < 4; c++)
      if ($urandom_range(n - 1) == 0) r[c] = ~r[c];
    return r;
  endfunction

  initial begin
    int nt, tpos, lv, nd, n;
    int tp[4];
    ld_en0 = 0; ld_ch0 = 0; ld_mode0 = 0; ld_p0 = 0; ld_d0 = 0;
    start0 = 0; stop0 = 0; clear0 = 0;
    ld_en1 = 0; ld_ch1 = 0; ld_mode1 = 0; ld_p1 = 0; ld_d1 = 0;
    start1 = 0; stop1 = 0; clear1 = 0;
    ld_en2 = 0; ld_ch2 = 0; ld_mode2 = 0; ld_p2 = 0; ld_d2 = 0;
    start2 = 0; stop2 = 0; clear2 = 0;
    #1 rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("reset_busy", int'(busy0), 0);
    chk("reset_tick", int'(tick0), 0);
    chk("reset_done", int'(done0), 0);

    // Async reset mid-run.
    cfg0(0, 1, 9, 0);
    pulse0(0);
    repeat (5) cycle();
    chk("prerst_busy", int'(busy0[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_busy", int'(busy0), 0);
    chk("rst_async_level", int'(level0), 0);
    cycle();
    rst = 1'b0;
    nt = 0;
    for (int j = 0; j < 15; j++) begin
      cycle();
      if (busy0[0] || tick0[0]) nt++;
    end
    chk("rst_stays_idle", nt, 0);

    // One-shot ch1, P=4.
    cfg0(1, 0, 4, 0);
    pulse0(1);
    chk("os_busy0", int'(busy0[1]), 1);
    nt = 0; tpos = -1;
    for (int j = 0; j < 12; j++) begin
      cycle();
      if (tick0[1]) begin nt++; tpos = k; end
      if (k == 4) chk("os_busy4", int'(busy0[1]), 1);
      if (k == 5) chk("os_busy5", int'(busy0[1]), 0);
    end
    chk("os_tick_pos", tpos, 5);
    chk("os_ticks", nt, 1);
    chk("os_done", int'(done0[1]), 1);

    // Periodic PWM ch2, P=9 D=3, then reload P=4.
    cfg0(2, 1, 9, 3);
    pulse0(2);
    nt = 0; lv = 0;
    for (int j = 0; j < 30; j++) begin
      cycle();
      if (tick0[2]) nt++;
      if (level0[2]) lv++;
    end
    chk("pwm_ticks", nt, 3);
    chk("pwm_level", lv, 9);
    cfg0(2, 1, 4, 3);
    n = 0;
    while (k < 52) begin
      cycle();
      if (tick0[2] && n < 3) begin tp[n] = k; n++; end
    end
    chk("pwm_reload_t0", tp[0], 40);
    chk("pwm_reload_t1", tp[1], 45);
    chk("pwm_reload_t2", tp[2], 50);
    clear0[2] = 1'b1;
    cycle();
    clear0[2] = 1'b0;

    // Hold ch3, P=7: short press then long press.
    cfg0(3, 2, 7, 0);
    start0[3] = 1'b1;
    for (int j = 0; j < 5; j++) cycle();
    chk("hold_short_busy", int'(busy0[3]), 1);
    start0[3] = 1'b0;
    nt = 0; nd = 0;
    for (int j = 0; j < 8; j++) begin
      cycle();
      if (tick0[3]) nt++;
      if (done0[3]) nd++;
    end
    chk("hold_short_ticks", nt, 0);
    chk("hold_short_done", nd, 0);
    start0[3] = 1'b1;
    k = -1; nt = 0; tpos = -1;
    for (int j = 0; j < 12; j++) begin
      cycle();
      if (tick0[3]) begin nt++; tpos = k; end
      if (k == 10) begin
        chk("hold_done_hi", int'(done0[3]), 1);
        chk("hold_level_hi", int'(level0[3]), 1);
      end
    end
    start0[3] = 1'b0;
    cycle();
    chk("hold_done_lo", int'(done0[3]), 0);
    chk("hold_ticks", nt, 1);
    chk("hold_tick_pos", tpos, 8);

    // Priorities on ch0, P=2 D=2.
    cfg0(0, 1, 2, 2);
    pulse0(0);
    cycle();
    stop0[0] = 1'b1;
    nt = 0;
    for (int j = 0; j < 6; j++) begin
      cycle();
      if (tick0[0]) nt++;
    end
    chk("stop_level_frozen", int'(level0[0]), 1);
    stop0[0] = 1'b0;
    while (k < 10) begin
      cycle();
      if (k < 10 && tick0[0]) nt++;
    end
    chk("stop_no_ticks", nt, 0);
    chk("stop_resume_tick", int'(tick0[0]), 1);
    cycle();
    cycle();
    clear0[0] = 1'b1;
    start0[0] = 1'b1;
    cycle();
    clear0[0] = 1'b0;
    start0[0] = 1'b0;
    chk("clr_start_tick", int'(tick0[0]), 0);
    chk("clr_start_busy", int'(busy0[0]), 0);

    // Prescale=4 bank: periodic P=1 plus one-shot P=2.
    ld_en1 = 1'b1; ld_ch1 = 1'b0; ld_mode1 = 2'b01; ld_p1 = 8'd1;
    cycle();
    ld_ch1 = 1'b1; ld_mode1 = 2'b00; ld_p1 = 8'd2;
    cycle();
    ld_en1 = 1'b0;
    start1 = 2'b11;
    cycle();
    start1 = 2'b00;
    n = 0; nt = 0;
    for (int j = 0; j < 40; j++) begin
      cycle();
      if (tick1[0] && n < 3) begin tp[n] = k; n++; end
      if (tick1[1]) nt++;
    end
    chk("ps_found", n, 3);
    chk("ps_int1", tp[1] - tp[0], 8);
    chk("ps_int2", tp[2] - tp[1], 8);
    chk("ps_os_ticks", nt, 1);
    chk("ps_os_done", int'(done1[1]), 1);
    start1 = 2'b00;

    // Random traffic on all three banks.
    for (int j = 0; j < 3000; j++) begin
      cycle();
      ld_en0 = ($urandom_range(3) == 0);
      ld_ch0 = 2'($urandom);
      ld_mode0 = 2'($urandom);
      ld_p0 = 16'($urandom_range(6));
      ld_d0 = 16'($urandom_range(8));
      start0 = tog(start0, 20);
      stop0 = tog(stop0, 12);
      clear0 = 4'($urandom_range(59) == 0) << $urandom_range(3);
      ld_en1 = ($urandom_range(3) == 0);
      ld_ch1 = 1'($urandom);
      ld_mode1 = 2'($urandom);
      ld_p1 = 8'($urandom_range(4));
      ld_d1 = 8'($urandom_range(6));
      start1 = 2'(tog(4'(start1), 20));
      stop1 = 2'(tog(4'(stop1), 12));
      clear1 = 2'($urandom_range(59) == 0) << $urandom_range(1);
      ld_en2 = ($urandom_range(3) == 0);
      ld_ch2 = 2'($urandom);
      ld_mode2 = 2'($urandom);
      ld_p2 = 12'($urandom_range(5));
      ld_d2 = 12'($urandom_range(7));
      start2 = 3'(tog(4'(start2), 20));
      stop2 = 3'(tog(4'(stop2), 12));
      clear2 = 3'($urandom_range(59) == 0) << $urandom_range(2);
    end
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
